color_detect: RTL

COLOR_DETECT -- requirements
Module: color_detect

---
 rtl/color_detect.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/color_detect.sv
// rtl/color_detect.sv - per-frame dominant color detector for RGB332 pixel streams
//
// Purpose:
//   Watches the capture stage's pixel strobe, classifies every pixel of a frame
//   as red, green, blue or unclassified, and at frame end publishes the class
//   counts plus the winning color through a valid/acknowledge result register.
//
// Ports:
//   pclk         in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   vsync        in   camera frame sync, high between frames
//   px_wr        in   one-cycle strobe per captured pixel
//   mem_px_addr  in   pixel address accompanying px_wr (monitored only)
//   mem_px_data  in   RGB332 pixel: R=[7:5], G=[4:2], B=[1:0]
//   res_ack      in   consumer acknowledge of the current result
//   res_valid    out  result registers hold an unacknowledged frame result
//   res_color    out  0 none, 1 red, 2 green, 3 blue
//   res_cnt_r/g/b out per-class pixel counts of the last frame
//   overrun      out  sticky: a result was overwritten before acknowledge
//
// Configuration:
//   COLOR_DETECT_ROI_EN  when defined, only pixels inside the ROI_* window are
//                        classified; the frame pixel counter still sees all.

module color_detect #(
  parameter int AW      = 17,
  parameter int NPIX    = 19200,
  parameter int HRES    = 160,
  parameter int MIN_CNT = 64,
  parameter int ROI_X0  = 40,
  parameter int ROI_X1  = 119,
  parameter int ROI_Y0  = 30,
  parameter int ROI_Y1  = 89
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          px_wr,
  input  logic [AW-1:0] mem_px_addr,
  input  logic [7:0]    mem_px_data,
  input  logic          res_ack,
  output logic          res_valid,
  output logic [1:0]    res_color,
  output logic [14:0]   res_cnt_r,
  output logic [14:0]   res_cnt_g,
  output logic [14:0]   res_cnt_b,
  output logic          overrun
);

  localparam int NROW = (NPIX + HRES - 1) / HRES;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int CW   = (HRES > 1) ? $clog2(HRES) : 1;
  // One extra row of headroom: the row counter steps past the last row on
  // the final pixel of a full frame.
  localparam int RW   = $clog2(NROW + 1);

  localparam logic [PW-1:0] NPIX_C   = PW'(NPIX);
  localparam logic [CW-1:0] COL_LAST = CW'(HRES - 1);
  localparam logic [14:0]   MIN_C    = 15'(MIN_CNT);
  localparam logic [14:0]   CNT_MAX  = 15'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           vsync_prev_q, vsync_prev_d;
  logic [PW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [14:0]    acc_r_q, acc_r_d;
  logic [14:0]    acc_g_q, acc_g_d;
  logic [14:0]    acc_b_q, acc_b_d;

  logic           res_valid_q, res_valid_d;
  logic [1:0]     res_color_q, res_color_d;
  logic [14:0]    res_cnt_r_q, res_cnt_r_d;
  logic [14:0]    res_cnt_g_q, res_cnt_g_d;
  logic [14:0]    res_cnt_b_q, res_cnt_b_d;
  logic           overrun_q, overrun_d;

  logic           vs_fall, vs_rise;
  logic           is_red, is_green, is_blue;
  logic           in_roi;
  logic [1:0]     win_color;
  logic [14:0]    win_cnt;
  logic           last_px;

  assign vs_fall = vsync_prev_q & ~vsync;
  assign vs_rise = ~vsync_prev_q & vsync;

  // A pixel belongs to a class only when that channel's MSB is set and the
  // other two channel MSBs are clear.
  assign is_red   = mem_px_data[7] & ~mem_px_data[4] & ~mem_px_data[1];
  assign is_green = mem_px_data[4] & ~mem_px_data[7] & ~mem_px_data[1];
  assign is_blue  = mem_px_data[1] & ~mem_px_data[7] & ~mem_px_data[4];

`ifdef COLOR_DETECT_ROI_EN
  localparam logic [CW-1:0] ROI_X0_C = CW'(ROI_X0);
  localparam logic [CW-1:0] ROI_X1_C = CW'(ROI_X1);
  localparam logic [RW-1:0] ROI_Y0_C = RW'(ROI_Y0);
  localparam logic [RW-1:0] ROI_Y1_C = RW'(ROI_Y1);

  assign in_roi = (col_q >= ROI_X0_C) && (col_q <= ROI_X1_C) &&
                  (row_q >= ROI_Y0_C) && (row_q <= ROI_Y1_C);
`else
  assign in_roi = 1'b1;
`endif

  // The address bus and the low channel bits carry no information for the
  // classifier; ROI bounds are folded in so every build references them.
  logic unused_ok;
  assign unused_ok = ^{mem_px_addr, mem_px_data[6:5], mem_px_data[3:2],
                       mem_px_data[0], 32'(ROI_X0), 32'(ROI_X1),
                       32'(ROI_Y0), 32'(ROI_Y1)};

  function automatic logic [14:0] sat_inc(input logic [14:0] v);
    return (v == CNT_MAX) ? v : v + 15'd1;
  endfunction

  // Winner selection: ">=" comparisons give red priority over green, and
  // green over blue, when counts tie.
  always_comb begin
    win_color = 2'd0;
    win_cnt   = 15'd0;
    if ((acc_r_q >= acc_g_q) && (acc_r_q >= acc_b_q)) begin
      win_color = 2'd1;
      win_cnt   = acc_r_q;
    end else if (acc_g_q >= acc_b_q) begin
      win_color = 2'd2;
      win_cnt   = acc_g_q;
    end else begin
      win_color = 2'd3;
      win_cnt   = acc_b_q;
    end
  end

  assign last_px = px_wr && ((pix_cnt_q + PW'(1)) == NPIX_C);

  always_comb begin
    state_d      = state_q;
    vsync_prev_d = vsync;
    pix_cnt_d    = pix_cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    acc_r_d      = acc_r_q;
    acc_g_d      = acc_g_q;
    acc_b_d      = acc_b_q;
    res_valid_d  = res_valid_q;
    res_color_d  = res_color_q;
    res_cnt_r_d  = res_cnt_r_q;
    res_cnt_g_d  = res_cnt_g_q;
    res_cnt_b_d  = res_cnt_b_q;
    overrun_d    = overrun_q;

    // Acknowledge of a held result; a new result in DECIDE takes precedence.
    if (res_ack && res_valid_q) begin
      res_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (vs_fall) begin
          pix_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
          acc_r_d   = '0;
          acc_g_d   = '0;
          acc_b_d   = '0;
          state_d   = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (px_wr) begin
          pix_cnt_d = pix_cnt_q + PW'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (in_roi) begin
            if (is_red)   acc_r_d = sat_inc(acc_r_q);
            if (is_green) acc_g_d = sat_inc(acc_g_q);
            if (is_blue)  acc_b_d = sat_inc(acc_b_q);
          end
        end
        if (last_px || vs_rise) begin
          state_d = ST_DECIDE;
        end
      end

      ST_DECIDE: begin
        res_cnt_r_d = acc_r_q;
        res_cnt_g_d = acc_g_q;
        res_cnt_b_d = acc_b_q;
        res_color_d = (win_cnt >= MIN_C) ? win_color : 2'd0;
        res_valid_d = 1'b1;
        // Overwriting an unacknowledged result flags overrun, unless the
        // consumer acknowledges the old one in this very cycle.
        if (res_valid_q) begin
          overrun_d = res_ack ? 1'b0 : 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vsync_prev_q <= 1'b0;
      pix_cnt_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      acc_r_q      <= '0;
      acc_g_q      <= '0;
      acc_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_color_q  <= 2'd0;
      res_cnt_r_q  <= '0;
      res_cnt_g_q  <= '0;
      res_cnt_b_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsync_prev_d;
      pix_cnt_q    <= pix_cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      acc_r_q      <= acc_r_d;
      acc_g_q      <= acc_g_d;
      acc_b_q      <= acc_b_d;
      res_valid_q  <= res_valid_d;
      res_color_q  <= res_color_d;
      res_cnt_r_q  <= res_cnt_r_d;
      res_cnt_g_q  <= res_cnt_g_d;
      res_cnt_b_q  <= res_cnt_b_d;
      overrun_q    <= overrun_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_color = res_color_q;
  assign res_cnt_r = res_cnt_r_q;
  assign res_cnt_g = res_cnt_g_q;
  assign res_cnt_b = res_cnt_b_q;
  assign overrun   = overrun_q;

endmodule
